// File: rtl/iterative_shift_ctrl_pkg.sv
// Shared definitions for the iterative shift sequencer: NZCV bit indices,
// shift-direction encoding, FSM state encoding and a flag packing helper.
package iterative_shift_ctrl_pkg;

    // NZCV status bit positions within statusOut
    localparam int unsigned ST_CARRY    = 0;
    localparam int unsigned ST_ZERO     = 1;
    localparam int unsigned ST_NEG      = 2;
    localparam int unsigned ST_OVERFLOW = 3;

    // Shift direction encoding carried on leftRight
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Assemble the 4-bit status word from individual flags; overflow is never
    // produced by a logical shift so it is always cleared.
    function automatic logic [3:0] pack_nzcv(input logic neg, input logic zero, input logic carry);
        logic [3:0] flags;
        flags              = 4'b0000;
        flags[ST_NEG]      = neg;
        flags[ST_ZERO]     = zero;
        flags[ST_CARRY]    = carry;
        flags[ST_OVERFLOW] = 1'b0;
        return flags;
    endfunction

endpackage

// File: rtl/iterative_shift_ctrl_step.sv
// Combinational single-position logical shift with zero fill.
// Reports the bit that falls off the end so the sequencer can build carry.
module shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);
    import iterative_shift_ctrl_pkg::*;

    // Move one position toward dir; expose the departing bit
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        if (dir == SH_RIGHT) begin
            next_value = {1'b0, value[WIDTH-1:1]};
            out_bit    = value[0];
        end else begin
            next_value = {value[WIDTH-2:0], 1'b0};
            out_bit    = value[WIDTH-1];
        end
    end

endmodule

// File: rtl/iterative_shift_ctrl.sv
// Multi-cycle logical shifter: one bit position per clock, valid/ready on
// both sides, result and NZCV status registered when the shift completes.
module iterative_shift_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             leftRight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut,
    output logic             busy
);
    import iterative_shift_ctrl_pkg::*;

    localparam int              CNTW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(WIDTH);

    state_e            state_r;
    state_e            state_n_s;
    logic [WIDTH-1:0]  shreg_r;
    logic              dir_r;
    logic [CNTW-1:0]   cnt_r;
    logic              big_r;
    logic              cbit_r;
    logic [WIDTH-1:0]  result_r;
    logic [3:0]        status_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              big_s;
    logic [CNTW-1:0]   amt_s;
    logic              cnt_zero_s;
    logic [WIDTH-1:0]  step_value_s;
    logic              step_bit_s;
    logic [3:0]        flags_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign statusOut = status_r;

    // Single shared one-position shifter for the SHIFT datapath
    shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (shreg_r),
        .dir        (dir_r),
        .next_value (step_value_s),
        .out_bit    (step_bit_s)
    );

    // Clamp the requested amount to WIDTH; anything beyond shifts out to zero
    always_comb begin
        big_s = (operand2 > WIDTH_V);
        if (big_s) begin
            amt_s = CNT_MAX;
        end else begin
            amt_s = CNTW'(operand2);
        end
    end

    // Status flags derived from the final shift register; carry is suppressed
    // for oversize amounts since the real last bit lies beyond the operand
    always_comb begin
        cnt_zero_s = (cnt_r == {CNTW{1'b0}});
        flags_s    = pack_nzcv(shreg_r[WIDTH-1],
                               (shreg_r == {WIDTH{1'b0}}),
                               cbit_r & ~big_r);
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_n_s = S_SHIFT;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_zero_s) begin
                    state_n_s = S_DONE;
                end else begin
                    state_n_s = S_SHIFT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n_s = S_IDLE;
                end else begin
                    state_n_s = S_DONE;
                end
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    // State register plus handshake/busy outputs registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s == S_IDLE);
            out_valid_r <= (state_n_s == S_DONE);
            busy_r      <= (state_n_s != S_IDLE);
        end
    end

    // Operand capture, per-clock shifting, and result/flag capture on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r  <= {WIDTH{1'b0}};
            dir_r    <= SH_LEFT;
            cnt_r    <= {CNTW{1'b0}};
            big_r    <= 1'b0;
            cbit_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            status_r <= 4'b0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg_r <= operand1;
                        dir_r   <= leftRight;
                        cnt_r   <= amt_s;
                        big_r   <= big_s;
                        cbit_r  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (!cnt_zero_s) begin
                        shreg_r <= step_value_s;
                        cbit_r  <= step_bit_s;
                        cnt_r   <= cnt_r - CNTW'(1);
                    end else begin
                        result_r <= shreg_r;
                        status_r <= flags_s;
                    end
                end
                S_DONE: begin
                    result_r <= result_r;
                    status_r <= status_r;
                end
                default: begin
                    cnt_r <= {CNTW{1'b0}};
                end
            endcase
        end
    end

endmodule
